// File: rtl/stage_exec_responder.sv
// rtl/stage_exec_responder.sv - downstream responder for the stageN_exec / stageN_exec_ready handshake
//
// Accepts operands over a 4-phase exec/exec_ready handshake and queues them in a FIFO.
// A fixed-latency execute unit turns each operand into operand+1 and offers it on a valid/ack port.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   exec_in, data_in    upstream request level and operand
//   exec_ready          acknowledge to upstream
//   result_data/valid   executed result, held until result_ack
//   result_ack          consumer takes the result
//   count_accepted      accepted operand count, wraps
//   busy                FIFO non-empty or execute unit active
//   protocol_err        sticky: operand changed while exec_in stayed high
module stage_exec_responder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int EXEC_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              exec_ready,
  output logic [DATA_W-1:0] result_data,
  output logic              result_valid,
  input  logic              result_ack,
  output logic [15:0]       count_accepted,
  output logic              busy,
  output logic              protocol_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CYC_W = $clog2(EXEC_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_INIT = CYC_W'(EXEC_CYCLES - 1);

  typedef enum logic {H_IDLE, H_WAIT_LOW} h_state_e;
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_DONE} e_state_e;

  h_state_e          h_state_q, h_state_d;
  e_state_e          e_state_q, e_state_d;
  logic              exec_ready_q, exec_ready_d;
  logic [DATA_W-1:0] captured_q, captured_d;
  logic              protocol_err_q, protocol_err_d;
  logic [15:0]       count_accepted_q, count_accepted_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] result_data_q, result_data_d;
  logic              result_valid_q, result_valid_d;
  logic              busy_q, busy_d;

  logic fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (occ_q == CNT_W'(DEPTH));
  assign fifo_empty = (occ_q == '0);
  // Pop looks only at registered occupancy, so a freshly pushed item waits one edge.
  assign push = (h_state_q == H_IDLE) && exec_in && !fifo_full;
  assign pop  = (e_state_q == E_IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_state_q        <= H_IDLE;
      e_state_q        <= E_IDLE;
      exec_ready_q     <= 1'b0;
      captured_q       <= '0;
      protocol_err_q   <= 1'b0;
      count_accepted_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      cnt_q            <= '0;
      operand_q        <= '0;
      result_data_q    <= '0;
      result_valid_q   <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      h_state_q        <= h_state_d;
      e_state_q        <= e_state_d;
      exec_ready_q     <= exec_ready_d;
      captured_q       <= captured_d;
      protocol_err_q   <= protocol_err_d;
      count_accepted_q <= count_accepted_d;
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      cnt_q            <= cnt_d;
      operand_q        <= operand_d;
      result_data_q    <= result_data_d;
      result_valid_q   <= result_valid_d;
      busy_q           <= busy_d;
    end
  end

  always_comb begin
    h_state_d = h_state_q;
    case (h_state_q)
      H_IDLE:     if (push) h_state_d = H_WAIT_LOW;
      H_WAIT_LOW: if (!exec_in) h_state_d = H_IDLE;
      default:    h_state_d = H_IDLE;
    endcase
  end

  always_comb begin
    e_state_d = e_state_q;
    case (e_state_q)
      E_IDLE:  if (pop) e_state_d = E_RUN;
      E_RUN:   if (cnt_q == '0) e_state_d = E_DONE;
      E_DONE:  if (result_ack) e_state_d = E_IDLE;
      default: e_state_d = E_IDLE;
    endcase
  end

  always_comb begin
    mem_d            = mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    captured_d       = captured_q;
    count_accepted_d = count_accepted_q;
    operand_d        = operand_q;
    cnt_d            = cnt_q;
    result_data_d    = result_data_q;
    result_valid_d   = result_valid_q;

    if (push) begin
      mem_d[wr_ptr_q]  = data_in;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      captured_d       = data_in;
      count_accepted_d = count_accepted_q + 16'd1;
    end
    if (pop) begin
      operand_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      cnt_d     = CYC_INIT;
    end
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);

    if (e_state_q == E_RUN) begin
      if (cnt_q == '0) begin
        result_data_d  = operand_q + DATA_W'(1);
        result_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CYC_W'(1);
      end
    end
    if (e_state_q == E_DONE && result_ack) result_valid_d = 1'b0;

    // exec_ready is high exactly while the handshake waits for exec_in to fall.
    exec_ready_d   = (h_state_d == H_WAIT_LOW);
    protocol_err_d = protocol_err_q ||
                     ((h_state_q == H_WAIT_LOW) && exec_in && (data_in != captured_q));
    busy_d         = (occ_d != '0) || (e_state_d != E_IDLE);
  end

  assign exec_ready     = exec_ready_q;
  assign result_data    = result_data_q;
  assign result_valid   = result_valid_q;
  assign count_accepted = count_accepted_q;
  assign busy           = busy_q;
  assign protocol_err   = protocol_err_q;

endmodule

// File: tb/tb_stage_exec_responder.sv
// tb/tb_stage_exec_responder.sv - self-checking bench for stage_exec_responder
module tb_stage_exec_responder;

  logic        clk;
  logic        rst;
  logic        exec_in;
  logic [7:0]  data_in;
  logic        exec_ready;
  logic [7:0]  result_data;
  logic        result_valid;
  logic        result_ack;
  logic [15:0] count_accepted;
  logic        busy;
  logic        protocol_err;

  stage_exec_responder #(.DATA_W(8), .DEPTH(4), .EXEC_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .exec_in        (exec_in),
    .data_in        (data_in),
    .exec_ready     (exec_ready),
    .result_data    (result_data),
    .result_valid   (result_valid),
    .result_ack     (result_ack),
    .count_accepted (count_accepted),
    .busy           (busy),
    .protocol_err   (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         ack_budget = 0;
  logic       ack_check  = 1'b0;
  logic [15:0] exp_count = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer: acks results while budget remains and scores them against the queue.
  initial result_ack = 1'b0;
  always @(negedge clk) begin
    if (ack_check) begin
      check("ack_drop", {31'd0, result_valid}, 32'd0);
      ack_check = 1'b0;
    end
    result_ack = 1'b0;
    if (rst && result_valid && ack_budget > 0) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("result", {24'd0, result_data}, {24'd0, sb.pop_front()});
      end
      ack_budget--;
      result_ack = 1'b1;
      ack_check  = 1'b1;
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    @(negedge clk);
    exec_in = 1'b1;
    data_in = d;
    n = 0;
    while (!exec_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, exec_ready}, 32'd1);
    exp_count = exp_count + 16'd1;
    exec_in = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exec_ready && n < 20);
    check("send_release", {31'd0, exec_ready}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || result_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_sb", sb.size(), 32'd0);
    check("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", {31'd0, result_valid}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n;
    int   seen;
    vecs[0] = '{din: 8'h05, exp: 8'h06};
    vecs[1] = '{din: 8'hFF, exp: 8'h00};
    vecs[2] = '{din: 8'h7F, exp: 8'h80};
    vecs[3] = '{din: 8'hA5, exp: 8'hA6};
    vecs[4] = '{din: 8'h00, exp: 8'h01};

    rst = 1'b0;
    exec_in = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_exec_ready", {31'd0, exec_ready}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result_data", {24'd0, result_data}, 32'd0);
    check("rst_count", {16'd0, count_accepted}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
    rst = 1'b1;

    // Single transfer with cycle-exact latency.
    sb.push_back(8'h06);
    @(negedge clk);
    exec_in = 1'b1;
    data_in = 8'h05;
    @(negedge clk);
    check("single_ready_rise", {31'd0, exec_ready}, 32'd1);
    check("single_count", {16'd0, count_accepted}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd1);
    exec_in = 1'b0;
    @(negedge clk);
    check("single_ready_fall", {31'd0, exec_ready}, 32'd0);
    @(negedge clk);
    check("single_valid_e2", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    check("single_valid_e3", {31'd0, result_valid}, 32'd0);
    @(negedge clk);
    check("single_valid_e4", {31'd0, result_valid}, 32'd1);
    check("single_data_e4", {24'd0, result_data}, 32'h06);
    exp_count = 16'd1;
    ack_budget = 1;
    drain();
    check("single_count_end", {16'd0, count_accepted}, {16'd0, exp_count});

    // Table-driven transfers.
    ack_budget = 1000;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(vecs[i].exp);
      send(vecs[i].din);
    end
    drain();
    check("table_count", {16'd0, count_accepted}, {16'd0, exp_count});

    // count_accepted wrap.
    force dut.count_accepted_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_accepted_q;
    exp_count = 16'hFFFF;
    check("wrap_preset", {16'd0, count_accepted}, 32'hFFFF);
    sb.push_back(8'h34);
    send(8'h33);
    drain();
    check("wrap_count", {16'd0, count_accepted}, 32'h0000);

    // Backpressure: result never acked until the FIFO is full.
    ack_budget = 0;
    for (int d = 8'h10; d <= 8'h14; d++) begin
      sb.push_back(8'(d + 1));
      send(8'(d));
    end
    wait_valid();
    check("bp_occ_full", {28'd0, dut.occ_q}, 32'd4);
    check("bp_first_result", {24'd0, result_data}, 32'h11);
    @(negedge clk);
    exec_in = 1'b1;
    data_in = 8'h15;
    repeat (4) @(negedge clk);
    check("bp_stalled", {31'd0, exec_ready}, 32'd0);
    @(posedge clk);
    #1 ack_budget = 1;
    @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!exec_ready && n < 10);
    check("bp_accept_within_2", {31'd0, (n - 1) <= 2 && exec_ready}, 32'd1);
    sb.push_back(8'h16);
    exp_count = exp_count + 16'd1;
    exec_in = 1'b0;
    @(negedge clk);
    ack_budget = 1000;
    drain();
    check("bp_count", {16'd0, count_accepted}, {16'd0, exp_count});

    // Push and pop on the same edge.
    ack_budget = 0;
    sb.push_back(8'h31);
    send(8'h30);
    sb.push_back(8'h41);
    send(8'h40);
    wait_valid();
    check("pp_occ_before", {28'd0, dut.occ_q}, 32'd1);
    @(posedge clk);
    #1 ack_budget = 1;
    @(negedge clk);
    @(negedge clk);
    exec_in = 1'b1;
    data_in = 8'h50;
    sb.push_back(8'h51);
    @(negedge clk);
    check("pp_occ_after", {28'd0, dut.occ_q}, 32'd1);
    check("pp_ready", {31'd0, exec_ready}, 32'd1);
    exp_count = exp_count + 16'd1;
    exec_in = 1'b0;
    @(negedge clk);
    ack_budget = 1000;
    drain();
    check("pp_count", {16'd0, count_accepted}, {16'd0, exp_count});

    // Protocol error: operand changes while exec_in stays high.
    ack_budget = 1000;
    sb.push_back(8'h21);
    @(negedge clk);
    exec_in = 1'b1;
    data_in = 8'h20;
    n = 0;
    while (!exec_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("perr_accept", {31'd0, exec_ready}, 32'd1);
    check("perr_clear_before", {31'd0, protocol_err}, 32'd0);
    data_in = 8'h21;
    @(negedge clk);
    check("perr_set", {31'd0, protocol_err}, 32'd1);
    check("perr_ready_held", {31'd0, exec_ready}, 32'd1);
    exp_count = exp_count + 16'd1;
    exec_in = 1'b0;
    @(negedge clk);
    drain();
    check("perr_sticky", {31'd0, protocol_err}, 32'd1);
    check("perr_single_write", {16'd0, count_accepted}, {16'd0, exp_count});

    // Reset during execute with two items queued.
    ack_budget = 0;
    for (int d = 8'h60; d <= 8'h63; d++) begin
      sb.push_back(8'(d + 1));
      send(8'(d));
    end
    wait_valid();
    @(posedge clk);
    #1 ack_budget = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_occ", {28'd0, dut.occ_q}, 32'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_exec_ready", {31'd0, exec_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
    check("mid_rst_data", {24'd0, result_data}, 32'd0);
    check("mid_rst_count", {16'd0, count_accepted}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_perr", {31'd0, protocol_err}, 32'd0);
    sb.delete();
    exp_count = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ack_budget = 1000;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid || busy) seen = 1;
    end
    check("post_rst_quiet", seen, 32'd0);
    sb.push_back(8'h71);
    send(8'h70);
    drain();
    check("post_rst_count", {16'd0, count_accepted}, {16'd0, exp_count});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
